// File: rtl/pico_mm_arbiter_pkg.sv
// Shared types and the round-robin search used by the PicoMm master arbiter.
// Sized for up to NM_MAX masters so other shared peripherals can reuse it.
package pico_arb_pkg;

  localparam int NM_MAX = 8;
  localparam int IW     = $clog2(NM_MAX);

  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
  } rd_tag_t;

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] idx;
  } rr_pick_t;

  // Search starts at ptr and wraps by explicit compare, so NM need not be a power of two
  function automatic rr_pick_t rr_pick(input logic [NM_MAX-1:0] req,
                                       input logic [IW-1:0]     ptr,
                                       input int                nm);
    rr_pick_t r;
    int       c;
    r = '0;
    for (int k = 0; k < NM_MAX; k++) begin
      c = int'(ptr) + k;
      if (c > nm - 1) c = c - nm;
      if (k < nm && !r.hit && c >= 0 && c < NM_MAX && req[c]) begin
        r.hit = 1'b1;
        r.idx = IW'(c);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pico_mm_arbiter_if.sv
// Bundle of the per-master request side and the single shared slave port.
interface pico_mm_arbiter_if #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [NM-1:0][AW-1:0] m_addr;
  logic [NM-1:0]         m_write;
  logic [NM-1:0]         m_read;
  logic [NM-1:0][DW-1:0] m_wrdata;
  logic [NM-1:0]         m_ack;
  logic [DW-1:0]         m_rddata;
  logic [NM-1:0]         m_rdvalid;
  logic [AW-1:0]         s_addr;
  logic                  s_write;
  logic                  s_read;
  logic [DW-1:0]         s_wrdata;
  logic [DW-1:0]         s_rddata;

  // Arbiter view: takes master requests, drives the slave port
  modport slave (
    input  m_addr, m_write, m_read, m_wrdata, s_rddata,
    output m_ack, m_rddata, m_rdvalid, s_addr, s_write, s_read, s_wrdata
  );

  modport master (
    output m_addr, m_write, m_read, m_wrdata, s_rddata,
    input  m_ack, m_rddata, m_rdvalid, s_addr, s_write, s_read, s_wrdata
  );

endinterface

// File: rtl/pico_mm_arbiter_rr_arbiter.sv
// Purely combinational round-robin picker: first request at or after i_ptr wins.
module rr_arbiter
  import pico_arb_pkg::*;
#(
  parameter int NM = 2,
  localparam int PW = $clog2(NM)
) (
  input  logic [NM-1:0] i_req,
  input  logic [PW-1:0] i_ptr,
  output logic          o_hit,
  output logic [PW-1:0] o_idx
);

  rr_pick_t w_pick;

  assign w_pick = rr_pick(NM_MAX'(i_req), IW'(i_ptr), NM);
  assign o_hit  = w_pick.hit;
  assign o_idx  = PW'(w_pick.idx);

endmodule

// File: rtl/pico_mm_arbiter.sv
// Shares one PicoMm slave port between NM masters with per-transaction
// round-robin grants, registered slave timing and tagged read returns.
module pico_mm_arbiter
  import pico_arb_pkg::*;
#(
  parameter int NM    = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int RDLAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  pico_mm_arbiter_if.slave   bus
);

  localparam int PW = $clog2(NM);

  logic [NM-1:0] w_req;
  logic          w_hit;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_ptr_nxt;
  logic [NM-1:0] w_rdvalid;

  logic [NM-1:0] r_ack;
  logic          r_write;
  logic          r_read;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wrdata;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_id;
  rd_tag_t       r_tag [RDLAT];

  // A master in its ack cycle may still show the old request, so mask it out
  assign w_req = (bus.m_write | bus.m_read) & ~r_ack;

  rr_arbiter #(.NM(NM)) u_rr (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_hit (w_hit),
    .o_idx (w_idx)
  );

  assign w_ptr_nxt = (w_idx == PW'(NM - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack    <= '0;
      r_write  <= 1'b0;
      r_read   <= 1'b0;
      r_addr   <= '0;
      r_wrdata <= '0;
      r_ptr    <= '0;
      r_id     <= '0;
      for (int i = 0; i < RDLAT; i++) r_tag[i] <= '0;
    end else begin
      r_ack   <= '0;
      r_write <= 1'b0;
      r_read  <= 1'b0;
      if (w_hit) begin
        r_ack[w_idx] <= 1'b1;
        r_addr       <= bus.m_addr[w_idx];
        r_wrdata     <= bus.m_wrdata[w_idx];
        r_write      <= bus.m_write[w_idx];
        r_read       <= bus.m_read[w_idx] & ~bus.m_write[w_idx];
        r_ptr        <= w_ptr_nxt;
        r_id         <= w_idx;
      end
      // Tag enters alongside s_read so the last stage lines up with s_rddata
      r_tag[0] <= '{v: r_read, id: IW'(r_id)};
      for (int i = 1; i < RDLAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_comb begin
    w_rdvalid = '0;
    for (int i = 0; i < NM; i++)
      w_rdvalid[i] = r_tag[RDLAT-1].v && (r_tag[RDLAT-1].id == IW'(i));
  end

  assign bus.m_ack     = r_ack;
  assign bus.m_rdvalid = w_rdvalid;
  assign bus.m_rddata  = bus.s_rddata;
  assign bus.s_addr    = r_addr;
  assign bus.s_wrdata  = r_wrdata;
  assign bus.s_write   = r_write;
  assign bus.s_read    = r_read;

endmodule

// File: tb/tb_pico_mm_arbiter.sv
// Scoreboard bench: DUT A (NM=2, RDLAT=1) and DUT B (NM=3, RDLAT=2), each
// with a small memory model standing in for the slave.
module tb_pico_mm_arbiter;

  typedef struct {
    int          cyc;
    logic [7:0]  ack;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    int          cyc;
    logic [7:0]  vld;
    logic [31:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rstA_n = 1'b0;
  logic rstB_n = 1'b0;
  int   cyc = 0;
  int   nCompared = 0;
  int   nMismatched = 0;
  int   ackCntB [3];

  acc_t qAcc [2][$];
  rd_t  qRd  [2][$];

  logic [31:0] memA [logic [31:0]];
  logic [31:0] memB [logic [31:0]];
  logic [31:0] pipeA = '0;
  logic [31:0] pipeB [2] = '{32'h0, 32'h0};

  pico_mm_arbiter_if #(.NM(2), .AW(32), .DW(32)) ifA ();
  pico_mm_arbiter_if #(.NM(3), .AW(32), .DW(32)) ifB ();

  pico_mm_arbiter #(.NM(2), .AW(32), .DW(32), .RDLAT(1)) dutA (
    .clk   (clk),
    .rst_n (rstA_n),
    .bus   (ifA)
  );

  pico_mm_arbiter #(.NM(3), .AW(32), .DW(32), .RDLAT(2)) dutB (
    .clk   (clk),
    .rst_n (rstB_n),
    .bus   (ifB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave models: write on s_write, return data RDLAT cycles after s_read
  always @(posedge clk) begin
    if (ifA.s_write) memA[ifA.s_addr] = ifA.s_wrdata;
    if (ifB.s_write) memB[ifB.s_addr] = ifB.s_wrdata;
  end

  always @(posedge clk) begin
    pipeA    <= (ifA.s_read && memA.exists(ifA.s_addr)) ? memA[ifA.s_addr] : 32'h0;
    pipeB[0] <= (ifB.s_read && memB.exists(ifB.s_addr)) ? memB[ifB.s_addr] : 32'h0;
    pipeB[1] <= pipeB[0];
  end

  assign ifA.s_rddata = pipeA;
  assign ifB.s_rddata = pipeB[1];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic nextCycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int d, input int m, input logic wr, input logic rd,
                               input logic [31:0] addr, input logic [31:0] data);
    if (d == 0) begin
      ifA.m_write[m] = wr; ifA.m_read[m] = rd; ifA.m_addr[m] = addr; ifA.m_wrdata[m] = data;
    end else begin
      ifB.m_write[m] = wr; ifB.m_read[m] = rd; ifB.m_addr[m] = addr; ifB.m_wrdata[m] = data;
    end
  endtask

  task automatic pushAcc(input int d, input int c, input logic [7:0] ack, input logic wr,
                         input logic rd, input logic [31:0] addr, input logic [31:0] data);
    acc_t e;
    e.cyc = c; e.ack = ack; e.wr = wr; e.rd = rd; e.addr = addr; e.data = data;
    qAcc[d].push_back(e);
  endtask

  task automatic pushRd(input int d, input int c, input logic [7:0] vld, input logic [31:0] data);
    rd_t e;
    e.cyc = c; e.vld = vld; e.data = data;
    qRd[d].push_back(e);
  endtask

  task automatic monAcc(input int d, input logic [7:0] ack, input logic wr, input logic rd,
                        input logic [31:0] addr, input logic [31:0] data);
    acc_t e;
    if (qAcc[d].size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL unexpectedAccess%0d: got ack %b wr %b rd %b at cycle %0d, required none",
               d, ack, wr, rd, cyc);
    end else begin
      e = qAcc[d].pop_front();
      checkOutput($sformatf("accCycle%0d", d), 64'(cyc), 64'(e.cyc));
      checkOutput($sformatf("accAckWrRdAddr%0d", d), {22'b0, ack, wr, rd, addr},
                  {22'b0, e.ack, e.wr, e.rd, e.addr});
      if (e.wr) checkOutput($sformatf("accWrData%0d", d), 64'(data), 64'(e.data));
    end
  endtask

  task automatic monRd(input int d, input logic [7:0] vld, input logic [31:0] data);
    rd_t e;
    if (qRd[d].size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL unexpectedRdValid%0d: got %b at cycle %0d, required none", d, vld, cyc);
    end else begin
      e = qRd[d].pop_front();
      checkOutput($sformatf("rdCycle%0d", d), 64'(cyc), 64'(e.cyc));
      checkOutput($sformatf("rdValidData%0d", d), {24'b0, vld, data}, {24'b0, e.vld, e.data});
    end
  endtask

  task automatic checkIdle(input int d);
    if (d == 0) begin
      checkOutput("idleCtlA", {ifA.s_write, ifA.s_read, 8'(ifA.m_ack), 8'(ifA.m_rdvalid)}, 64'h0);
      checkOutput("idleAddrA", 64'(ifA.s_addr), 64'h0);
      checkOutput("idleWrDataA", 64'(ifA.s_wrdata), 64'h0);
    end else begin
      checkOutput("idleCtlB", {ifB.s_write, ifB.s_read, 8'(ifB.m_ack), 8'(ifB.m_rdvalid)}, 64'h0);
      checkOutput("idleAddrB", 64'(ifB.s_addr), 64'h0);
      checkOutput("idleWrDataB", 64'(ifB.s_wrdata), 64'h0);
    end
  endtask

  // Monitor: pops expectations whenever a DUT shows an access or a read return
  always @(negedge clk) begin
    if (ifA.s_write || ifA.s_read || (ifA.m_ack != '0))
      monAcc(0, 8'(ifA.m_ack), ifA.s_write, ifA.s_read, ifA.s_addr, ifA.s_wrdata);
    if (ifA.m_rdvalid != '0) monRd(0, 8'(ifA.m_rdvalid), ifA.m_rddata);
    if (ifB.s_write || ifB.s_read || (ifB.m_ack != '0))
      monAcc(1, 8'(ifB.m_ack), ifB.s_write, ifB.s_read, ifB.s_addr, ifB.s_wrdata);
    if (ifB.m_rdvalid != '0) monRd(1, 8'(ifB.m_rdvalid), ifB.m_rddata);
    for (int i = 0; i < 3; i++) if (ifB.m_ack[i] === 1'b1) ackCntB[i]++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    ifA.m_write = '0; ifA.m_read = '0; ifA.m_addr = '0; ifA.m_wrdata = '0;
    ifB.m_write = '0; ifB.m_read = '0; ifB.m_addr = '0; ifB.m_wrdata = '0;
    memB[32'h0001_0000] = 32'd99;
    memB[32'h0001_0004] = 32'd33;
    ackCntB = '{0, 0, 0};

    nextCycle(2);
    checkIdle(0);
    checkIdle(1);
    rstA_n = 1'b1;
    rstB_n = 1'b1;
    nextCycle(1);

    // Single master write then read-back on A
    c = cyc;
    applyStimulus(0, 0, 1'b1, 1'b0, 32'h0000_0c00, 32'h1234_5678);
    pushAcc(0, c + 1, 8'b01, 1'b1, 1'b0, 32'h0000_0c00, 32'h1234_5678);
    nextCycle(2);
    c = cyc;
    applyStimulus(0, 0, 1'b0, 1'b1, 32'h0000_0c00, 32'h0);
    pushAcc(0, c + 1, 8'b01, 1'b0, 1'b1, 32'h0000_0c00, 32'h0);
    pushRd(0, c + 2, 8'b01, 32'h1234_5678);
    nextCycle(2);
    applyStimulus(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle(3);

    // Contention from a fresh pointer: m0, m1, m0, m1 back to back
    rstA_n = 1'b0;
    nextCycle(1);
    rstA_n = 1'b1;
    c = cyc;
    applyStimulus(0, 0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_00a0);
    applyStimulus(0, 1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_00b1);
    pushAcc(0, c + 1, 8'b01, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_00a0);
    pushAcc(0, c + 2, 8'b10, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_00b1);
    pushAcc(0, c + 3, 8'b01, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_00a0);
    pushAcc(0, c + 4, 8'b10, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_00b1);
    nextCycle(4);
    applyStimulus(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle(3);

    // Lone master m1 holds a read for 10 cycles: 5 grants on alternate cycles
    c = cyc;
    applyStimulus(0, 1, 1'b0, 1'b1, 32'h0000_0c00, 32'h0);
    for (int j = 0; j < 5; j++) begin
      pushAcc(0, c + 1 + 2 * j, 8'b10, 1'b0, 1'b1, 32'h0000_0c00, 32'h0);
      pushRd(0, c + 2 + 2 * j, 8'b10, 32'h1234_5678);
    end
    nextCycle(10);
    applyStimulus(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle(3);

    // Reset right after s_read: read dropped, outputs cleared, pointer back to m0
    c = cyc;
    applyStimulus(0, 0, 1'b0, 1'b1, 32'h0000_0c00, 32'h0);
    pushAcc(0, c + 1, 8'b01, 1'b0, 1'b1, 32'h0000_0c00, 32'h0);
    nextCycle(1);
    rstA_n = 1'b0;
    nextCycle(1);
    rstA_n = 1'b1;
    checkIdle(0);
    applyStimulus(0, 0, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0055);
    applyStimulus(0, 1, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0066);
    pushAcc(0, c + 3, 8'b01, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0055);
    pushAcc(0, c + 4, 8'b10, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0066);
    nextCycle(2);
    applyStimulus(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle(1);
    applyStimulus(0, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle(3);

    // Interleaved reads on B (RDLAT=2): each returns 3 cycles after its request
    c = cyc;
    applyStimulus(1, 0, 1'b0, 1'b1, 32'h0001_0000, 32'h0);
    pushAcc(1, c + 1, 8'b001, 1'b0, 1'b1, 32'h0001_0000, 32'h0);
    pushRd(1, c + 3, 8'b001, 32'd99);
    nextCycle(1);
    applyStimulus(1, 1, 1'b0, 1'b1, 32'h0001_0004, 32'h0);
    pushAcc(1, c + 2, 8'b010, 1'b0, 1'b1, 32'h0001_0004, 32'h0);
    pushRd(1, c + 4, 8'b010, 32'd33);
    nextCycle(1);
    applyStimulus(1, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle(1);
    applyStimulus(1, 1, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle(4);

    // Fairness on B: pointer sits at 2 after the m1 grant, so order is m2, m0, m1, ...
    ackCntB = '{0, 0, 0};
    c = cyc;
    for (int m = 0; m < 3; m++)
      applyStimulus(1, m, 1'b1, 1'b0, 32'h0000_2000 + 32'(4 * m), 32'h0000_00f0 + 32'(m));
    for (int j = 0; j < 30; j++) begin
      int m;
      m = (2 + j) % 3;
      pushAcc(1, c + 1 + j, 8'(1 << m), 1'b1, 1'b0, 32'h0000_2000 + 32'(4 * m),
              32'h0000_00f0 + 32'(m));
    end
    nextCycle(30);
    for (int m = 0; m < 3; m++) applyStimulus(1, m, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle(4);
    for (int m = 0; m < 3; m++)
      checkOutput($sformatf("fairGrants_m%0d", m), 64'(ackCntB[m]), 64'd10);

    nextCycle(3);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("pendingAccesses%0d", d), 64'(qAcc[d].size()), 64'd0);
      checkOutput($sformatf("pendingReads%0d", d), 64'(qRd[d].size()), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/pico_mm_arbiter.md
Name: pico_mm_arbiter

Overview:
- Shares one PicoMm slave port (the intercon's upstream side) between NM bus masters, e.g. the CU plus a DMA or debug master.
- Arbitrates per transaction with round-robin priority and forwards the winner's single-cycle read or write with registered timing.
- Returns read data to the originating master with an explicit valid strobe.
- Sits between the masters and the PicoMmIntercon master port.

Parameters:
- NM, 2, number of masters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- RDLAT, 1, slave read latency in cycles from s_read to s_rddata (1..4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- m_addr  in  NM x AW  per-master address.
- m_write  in  NM  per-master write request; held until m_ack.
- m_read  in  NM  per-master read request; held until m_ack.
- m_wrdata  in  NM x DW  per-master write data.
- m_ack  out  NM  one-cycle pulse: request accepted; master may drop or change its request next cycle.
- m_rddata  out  DW  read data, broadcast to all masters.
- m_rdvalid  out  NM  one-cycle pulse to the originating master when m_rddata is valid.
- s_addr  out  AW  to slave.
- s_write  out  1  to slave.
- s_read  out  1  to slave.
- s_wrdata  out  DW  to slave.
- s_rddata  in  DW  from slave, valid RDLAT cycles after s_read.

Behaviour:
- Reset (rst_n low at a clk edge):
  - s_write, s_read, m_ack, m_rdvalid all 0; s_addr and s_wrdata 0.
  - Round-robin pointer set to master 0 (master 0 has highest priority).
  - Read-tag pipeline cleared, so any in-flight read is dropped and no m_rdvalid is issued for it.
- Requests:
  - req[i] = m_write[i] | m_read[i], masked by m_ack[i] (a master is ineligible in its ack cycle because it may still be holding the old request).
  - If both m_write[i] and m_read[i] are set, the access is a write and no m_rdvalid follows.
- Arbitration (combinational, cycle t):
  - Search eligible requests starting at pointer p, wrapping at NM-1 -> 0. The first hit g is the grant.
  - If no request is eligible, there is no grant and p is unchanged.
- Cycle t+1 (registered):
  - s_addr and s_wrdata take master g's values.
  - s_write = write_g; s_read = read_g & ~write_g.
  - m_ack[g] = 1; p <= (g+1) mod NM.
  - With no grant, s_write and s_read are 0, and s_addr/s_wrdata hold their previous values.
- Read return:
  - A tag pipeline RDLAT deep carries {valid, g}.
  - At cycle t+1+RDLAT: m_rdvalid[g] = 1, and m_rddata = s_rddata passed through combinationally.
- Throughput:
  - One slave access per cycle when at least two masters alternate.
  - A lone master gets one access every 2 cycles because of the ack-cycle mask.
- Fairness: with all NM masters requesting continuously, each master is granted exactly once in every NM consecutive grants.
- Simultaneous events: a new grant may issue in the same cycle a previous read's m_rdvalid fires. Tags are pipelined, so there is no limit on outstanding reads beyond RDLAT.
- Widths: the pointer and grant index are $clog2(NM) bits. Wrap-around uses an explicit compare to NM-1, so non-power-of-2 NM works.

Decomposition:
- Package pico_arb_pkg holds:
  - the function rr_pick(req, ptr) returning {hit, idx};
  - a localparam computing the index width from NM;
  - the typedef for the read tag struct {logic v; logic [IW-1:0] id;}.
- Sub-module rr_arbiter (NM; inputs req, ptr; outputs hit, idx) is purely combinational and reusable by other shared peripherals.
- The top level contains the output registers, the pointer and the tag shift register.

Test Plan:
- Single master, reset: NM=2, RDLAT=1; after reset, m0 writes 0x0000_0c00 <- 0x1234_5678. Required: m_ack[0] and s_write=1 with matching addr/data one cycle after the request. m0 then reads 0x0000_0c00 through SpRamRf. Required: m_rdvalid[0]=1 with m_rddata=0x1234_5678 exactly 2 cycles after the request cycle, and m_rdvalid[1] stays 0.
- Contention: m0 and m1 both request writes continuously in the same cycle. Required grant order m0, m1, m0, m1, and s_write high every cycle after the first.
- Lone-master rate: m1 holds m_read for 10 cycles. Required: exactly 5 m_ack[1] pulses, on alternating cycles.
- Read routing with RDLAT=2: interleaved reads m0 @0x0001_0000 (PWM period=99) and m1 @0x0001_0004 (duty=33). Required: m_rdvalid[0] with 99, then m_rdvalid[1] with 33, each 3 cycles after its own request.
- Fairness, NM=3: all three masters request continuously for 30 grants. Required: each gets 10 grants, never the same master twice in a row.
- Reset mid-operation: rst_n driven low for 1 cycle immediately after s_read. Required: no m_rdvalid for that read, all outputs 0, and the next grant goes to m0.
